// File: rtl/uop_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uop_scheduler
// Description : Execution-side issue stage behind the reservation station.
//               It takes one 20-bit uop per issue and checks its registers
//               against an 8-entry busy scoreboard. It then sends the uop to
//               the single-cycle ALU (ack in the same cycle) or to the memory
//               port (ack after the memory handshake). Loads return their data
//               to the station through rs_mem_data / rs_mem_wr.
//
// Uop fields  : [19:12] ALU op/flag mask (opaque, passed through)
//               [11:8]  dest register (bit 3 set = no register dest)
//               [7:6]   mem op: 00 none, 01 load, 10 store, 11 none
//               [5:3]   src A        [2:0] src B
//
// Ports       : clk, a_rst (async, active-low)
//               rs_uop/rs_data        -> uop and operand from the station
//               rs_sched_ack          <- uop consumed this cycle
//               rs_mem_data/rs_mem_wr <- load result and its 1-cycle strobe
//               alu_valid/alu_uop     <- ALU issue strobe and uop
//               alu_wb_valid/dest     -> ALU write-back, clears busy bit
//               rd_sel/rd_data        <> register read of store data
//               mem_req/we/addr/wdata <- memory request, held until mem_ack
//               mem_ack/mem_rdata     -> memory completion and read data
//               mem_err               <- sticky memory timeout flag
//               stall_count           <- saturating stall cycle counter
//
// Config      : `define UOP_SCHED_STALL_CNT_EN enables stall_count.
//               Without the define, stall_count is tied to zero.
// Revision    : 1.0  initial release
// ============================================================================
module uop_scheduler #(
    parameter logic [19:0] NOP_UOP     = 20'h00F00,
    parameter int          NREGS       = 8,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic [19:0] rs_uop,
    input  logic [15:0] rs_data,
    output logic        rs_sched_ack,
    output logic [15:0] rs_mem_data,
    output logic        rs_mem_wr,
    output logic        alu_valid,
    output logic [19:0] alu_uop,
    input  logic        alu_wb_valid,
    input  logic [2:0]  alu_wb_dest,
    output logic [2:0]  rd_sel,
    input  logic [15:0] rd_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        mem_err,
    output logic [15:0] stall_count
);

    localparam logic [1:0] ST_ISSUE    = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_MEM_DONE = 2'd2;

    // The timer counts 0 .. MEM_TIMEOUT-1. The last value is the final wait cycle.
    localparam int              c_TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit              c_TMO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST =
        c_TMO_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    // ------------------------------------------------------------------
    // Uop decode
    // ------------------------------------------------------------------
    logic [3:0] w_dest;
    logic [2:0] w_src_a;
    logic [2:0] w_src_b;
    logic       w_is_nop;
    logic       w_is_load;
    logic       w_is_store;

    assign w_dest     = rs_uop[11:8];
    assign w_src_a    = rs_uop[5:3];
    assign w_src_b    = rs_uop[2:0];
    assign w_is_nop   = (rs_uop == NOP_UOP);
    assign w_is_load  = (rs_uop[7:6] == 2'b01);
    assign w_is_store = (rs_uop[7:6] == 2'b10);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         state_q,       state_d;
    logic [NREGS-1:0]   busy_q,        busy_d;
    logic               mem_req_q,     mem_req_d;
    logic               mem_we_q,      mem_we_d;
    logic [15:0]        mem_addr_q,    mem_addr_d;
    logic [15:0]        mem_wdata_q,   mem_wdata_d;
    logic               is_load_q,     is_load_d;
    logic [15:0]        rs_mem_data_q, rs_mem_data_d;
    logic               rs_mem_wr_q,   rs_mem_wr_d;
    logic               mem_err_q,     mem_err_d;
    logic [c_TMO_W-1:0] timer_q,       timer_d;

    // A write-back in this cycle releases its register at once. This lets a
    // dependent uop issue in the same cycle as the producer's write-back.
    logic [NREGS-1:0] w_wb_mask;
    logic [NREGS-1:0] w_busy_eff;
    logic             w_hazard;
    logic             w_alu_valid;
    logic             w_ack;

    assign w_wb_mask  = alu_wb_valid ? (NREGS'(1) << alu_wb_dest) : '0;
    assign w_busy_eff = busy_q & ~w_wb_mask;
    assign w_hazard   = w_busy_eff[w_src_a] | w_busy_eff[w_src_b] |
                        (~w_dest[3] & w_busy_eff[w_dest[2:0]]);

    always_comb begin
        state_d       = state_q;
        busy_d        = w_busy_eff;   // clearing a non-busy bit is a no-op
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        is_load_d     = is_load_q;
        rs_mem_data_d = rs_mem_data_q;
        rs_mem_wr_d   = 1'b0;
        mem_err_d     = mem_err_q;
        timer_d       = timer_q;
        w_alu_valid   = 1'b0;
        w_ack         = 1'b0;

        case (state_q)
            ST_ISSUE: begin
                // The reset check keeps the combinational strobes quiet
                // while reset is held, even though the uop input is live.
                if (a_rst) begin
                    if (w_is_nop) begin
                        w_ack = 1'b1;
                    end else if (!w_hazard) begin
                        if (w_is_load || w_is_store) begin
                            mem_req_d   = 1'b1;
                            mem_we_d    = w_is_store;
                            mem_addr_d  = rs_data;
                            mem_wdata_d = rd_data;
                            is_load_d   = w_is_load;
                            timer_d     = '0;
                            state_d     = ST_MEM_WAIT;
                        end else begin
                            w_alu_valid = 1'b1;
                            w_ack       = 1'b1;
                            // This set comes after the write-back clear, so a
                            // set and a clear of one register leave it busy.
                            if (!w_dest[3]) begin
                                busy_d[w_dest[2:0]] = 1'b1;
                            end
                        end
                    end
                end
            end

            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_MEM_DONE;
                    if (is_load_q) begin
                        rs_mem_data_d = mem_rdata;
                        rs_mem_wr_d   = 1'b1;
                    end
                end else if (c_TMO_EN && (timer_q == c_TMO_LAST)) begin
                    // Abandon the request. The uop is still acked so the
                    // station does not deadlock; no load data is returned.
                    mem_req_d = 1'b0;
                    mem_err_d = 1'b1;
                    w_ack     = 1'b1;
                    state_d   = ST_ISSUE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_MEM_DONE: begin
                w_ack   = 1'b1;
                state_d = ST_ISSUE;
            end

            default: begin
                state_d = ST_ISSUE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q       <= ST_ISSUE;
            busy_q        <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 16'd0;
            mem_wdata_q   <= 16'd0;
            is_load_q     <= 1'b0;
            rs_mem_data_q <= 16'd0;
            rs_mem_wr_q   <= 1'b0;
            mem_err_q     <= 1'b0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            is_load_q     <= is_load_d;
            rs_mem_data_q <= rs_mem_data_d;
            rs_mem_wr_q   <= rs_mem_wr_d;
            mem_err_q     <= mem_err_d;
            timer_q       <= timer_d;
        end
    end

    // ------------------------------------------------------------------
    // Stall counter (optional)
    // ------------------------------------------------------------------
`ifdef UOP_SCHED_STALL_CNT_EN
    logic        w_stall_inc;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign w_stall_inc = (state_q == ST_MEM_WAIT) ||
                         ((state_q == ST_ISSUE) && a_rst && !w_is_nop && w_hazard);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_stall_inc && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'd0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rs_sched_ack = w_ack;
    assign rs_mem_data  = rs_mem_data_q;
    assign rs_mem_wr    = rs_mem_wr_q;
    assign alu_valid    = w_alu_valid;
    assign alu_uop      = w_alu_valid ? rs_uop : 20'd0;
    assign rd_sel       = a_rst ? w_src_a : 3'd0;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_err      = mem_err_q;

endmodule
`default_nettype wire

// File: doc/uop_scheduler.md
Name: uop_scheduler

Overview:
- Execution-side issue stage, directly downstream of the reservation station.
- Consumes one 20-bit micro-op per issue from the station's next-uop output, together with the station's 16-bit operand/temp value.
- Tracks register hazards with an 8-entry scoreboard and issues each uop either to the single-cycle ALU or to the memory port.
- Handshakes completion back to the station via ack and memory-data write-back.

Parameters:
- NOP_UOP, 20'h00F00, encoding consumed without issue.
- NREGS, 8, architectural registers tracked by scoreboard (fixed at 8; source fields are 3 bits).
- MEM_TIMEOUT, 255, cycles waited for mem_ack before aborting; 0 disables timeout.

Ports:
- clk  in  1  clock
- a_rst  in  1  reset, asynchronous, active-low
- rs_uop  in  20  next uop from station
- rs_data  in  16  station operand/temp value
- rs_sched_ack  out  1  uop consumed this cycle
- rs_mem_data  out  16  load result to station
- rs_mem_wr  out  1  rs_mem_data valid (1-cycle pulse)
- alu_valid  out  1  ALU issue strobe
- alu_uop  out  20  uop issued to ALU
- alu_wb_valid  in  1  ALU write-back this cycle
- alu_wb_dest  in  3  register written back
- rd_sel  out  3  register read select (store data)
- rd_data  in  16  register read data
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = store
- mem_addr  out  16  address
- mem_wdata  out  16  store data
- mem_ack  in  1  memory done, read data valid
- mem_rdata  in  16  read data
- mem_err  out  1  sticky timeout flag
- stall_count  out  16  see Optional Feature

Behaviour:
- Uop fields:
  - [19:12] ALU op/flag mask (opaque, passed through).
  - [11:8] dest; 0-7 = register, bit3 set = no register dest.
  - [7:6] mem op: 00 none, 01 load, 10 store, 11 reserved (treated as none).
  - [5:3] src A; [2:0] src B.
- Reset: all outputs 0, scoreboard clear, state ISSUE, mem_err 0, counters 0.
- States: ISSUE, MEM_WAIT, MEM_DONE.
- ISSUE, uop == NOP_UOP:
  - rs_sched_ack=1 same cycle; no issue; scoreboard unchanged.
- ISSUE, hazard:
  - Hazard = busy[srcA] | busy[srcB] | (dest<8 & busy[dest]).
  - Bypass: a register whose write-back (alu_wb_valid & alu_wb_dest match) occurs in the same cycle is not busy.
- ISSUE, no hazard, mem op none:
  - alu_valid=1, alu_uop=rs_uop, rs_sched_ack=1 (combinational, same cycle).
  - busy[dest] set at next edge if dest<8.
- ISSUE, no hazard, load or store:
  - Register mem_addr=rs_data, mem_we, and mem_wdata=rd_data (rd_sel=srcA combinationally).
  - mem_req=1 from next cycle; go to MEM_WAIT; no ack yet.
- MEM_WAIT:
  - mem_req/addr/we/wdata held stable until mem_ack.
  - On mem_ack:
    - Load: rs_mem_data<=mem_rdata; rs_mem_wr pulse and rs_sched_ack pulse next cycle (MEM_DONE).
    - Store: ack only.
- MEM_DONE: one cycle → ISSUE.
- Latency: ALU uop 0 cycles to ack; memory uop = 2 + memory wait cycles.
- Scoreboard update rules:
  - Simultaneous clear (write-back) and set (new issue) of the same register: set wins.
  - Write-back to a non-busy register: ignored.
- Timeout:
  - If MEM_TIMEOUT≠0 and mem_ack is absent for MEM_TIMEOUT cycles in MEM_WAIT: drop mem_req, set mem_err, ack uop (no rs_mem_wr), → ISSUE.
  - mem_err clears only on reset.
- Back-to-back: at most one ack per cycle; no new uop is examined while in MEM_WAIT/MEM_DONE.
- Reset mid-operation: mem_req drops immediately (async); pending request abandoned; scoreboard cleared.

Optional Feature:
- Macro UOP_SCHED_STALL_CNT_EN.
- Defined: stall_count increments, saturating at 16'hFFFF, every cycle in ISSUE where the uop is not NOP and a hazard blocks issue, and every MEM_WAIT cycle.
- Not defined: stall_count tied to 0; no counter logic.

Test Plan:
- Reset with mem_req high mid-MEM_WAIT → all outputs 0 immediately; after release, uop 20'h00F00 → rs_sched_ack=1 same cycle, alu_valid=0.
- ALU uop dest=2 (20'hA0200), then uop srcA=2 next cycle → second uop stalls (no ack) until alu_wb_valid, alu_wb_dest=2; same-cycle bypass → issued that cycle.
- Load uop 20'h00F40, rs_data=16'h1234, mem_ack after 3 cycles with mem_rdata=16'hBEEF → mem_addr=1234 held stable; rs_mem_wr pulse with BEEF and ack one cycle after mem_ack.
- Store uop srcA=5 (20'h00F a8), rd_data=16'h5555 → mem_we=1, mem_wdata=5555; ack cycle after mem_ack; no rs_mem_wr.
- MEM_TIMEOUT=4, no mem_ack → mem_req drops after 4 wait cycles, mem_err=1 sticky, uop acked.
- With UOP_SCHED_STALL_CNT_EN: 3 hazard cycles + 4 mem-wait cycles → stall_count=7; without the macro → stall_count=0 throughout.
